// File: rtl/poly_note_player_pkg.sv
// Shared encodings and constants for the multi-voice note player.
package poly_note_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_OFF    = 2'b11
  } wave_e;

  typedef enum logic {
    V_IDLE   = 1'b0,
    V_ACTIVE = 1'b1
  } voice_state_e;

  localparam int SAMPLE_RATE = 48000;
  localparam int NOTE_REST   = 0;

endpackage

// File: rtl/poly_note_player_note_step_rom.sv
// Note code to phase step lookup; table values are fixed at elaboration.
module note_step_rom
  import poly_note_pkg::*;
#(
  parameter int NOTE_W  = 6,
  parameter int PHASE_W = 20
) (
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step
);

  localparam int ENTRIES = 2 ** NOTE_W;

  // Equal-tempered pitch with code 49 = A4 (440 Hz), rounded to nearest step.
  function automatic logic [PHASE_W-1:0] step_of(input int n);
    real freq;
    real scaled;
    if (n == NOTE_REST) return '0;
    freq   = 440.0 * (2.0 ** (real'(n - 49) / 12.0));
    scaled = freq * (2.0 ** PHASE_W) / real'(SAMPLE_RATE);
    return PHASE_W'($rtoi(scaled + 0.5));
  endfunction

  logic [PHASE_W-1:0] step_table [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    localparam logic [PHASE_W-1:0] STEP_VAL = step_of(g);
    assign step_table[g] = STEP_VAL;
  end

  assign step = step_table[note];

endmodule

// File: rtl/poly_note_player.sv
// Multi-voice note player: per-voice duration/phase state, waveform shaping and a mixed sample pipeline.
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int PHASE_W    = 20,
  parameter int SAMPLE_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play_enable,
  input  logic [1:0]                     wave_mode,
  input  logic [NUM_VOICES-1:0]          load_new_note,
  input  logic [NUM_VOICES*NOTE_W-1:0]   note_to_load,
  input  logic [NUM_VOICES*DUR_W-1:0]    duration_to_load,
  output logic [NUM_VOICES-1:0]          done_with_note,
  input  logic                           beat,
  input  logic                           generate_next_sample,
  output logic signed [SAMPLE_W-1:0]     sample_out,
  output logic                           new_sample_ready
);

  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int SUM_W = SAMPLE_W + SHIFT;
  localparam logic signed [SAMPLE_W-1:0] FULL_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  voice_state_e          state_q [NUM_VOICES];
  voice_state_e          state_d [NUM_VOICES];
  logic [NOTE_W-1:0]     note_q  [NUM_VOICES];
  logic [NOTE_W-1:0]     note_d  [NUM_VOICES];
  logic [DUR_W-1:0]      count_q [NUM_VOICES];
  logic [DUR_W-1:0]      count_d [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]    phase_add [NUM_VOICES];
  logic [PHASE_W-1:0]    step    [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] wave_d [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] wave_q [NUM_VOICES];

  logic                       stage1_valid;
  logic signed [SUM_W-1:0]    mix_sum;
  logic signed [SUM_W-1:0]    mix_shifted;
  wave_e                      mode;

  assign mode = wave_e'(wave_mode);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    note_step_rom #(
      .NOTE_W  (NOTE_W),
      .PHASE_W (PHASE_W)
    ) u_rom (
      .note (note_q[g]),
      .step (step[g])
    );
    assign done_with_note[g] = (state_q[g] == V_IDLE);
  end

  // Triangle folds the top SAMPLE_W+1 phase bits so the ramp rises then falls.
  function automatic logic signed [SAMPLE_W-1:0] shape(input wave_e m, input logic [PHASE_W-1:0] p);
    logic [SAMPLE_W:0]   top;
    logic [SAMPLE_W-1:0] fold;
    top  = p[PHASE_W-1 -: SAMPLE_W+1];
    fold = top[SAMPLE_W] ? ~top[SAMPLE_W-1:0] : top[SAMPLE_W-1:0];
    case (m)
      WAVE_SQUARE: shape = p[PHASE_W-1] ? -FULL_POS : FULL_POS;
      WAVE_SAW:    shape = {~p[PHASE_W-1], p[PHASE_W-2 -: SAMPLE_W-1]};
      WAVE_TRI:    shape = {~fold[SAMPLE_W-1], fold[SAMPLE_W-2:0]};
      default:     shape = '0;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      state_d[i]   = state_q[i];
      note_d[i]    = note_q[i];
      count_d[i]   = count_q[i];
      phase_d[i]   = phase_q[i];
      wave_d[i]    = '0;
      phase_add[i] = phase_q[i] + step[i];

      if (generate_next_sample && play_enable && state_q[i] == V_ACTIVE) begin
        phase_d[i] = phase_add[i];
        if (note_q[i] != NOTE_W'(NOTE_REST)) begin
          wave_d[i] = shape(mode, phase_add[i]);
        end
      end

      if (beat && play_enable && state_q[i] == V_ACTIVE) begin
        count_d[i] = count_q[i] - DUR_W'(1);
        if (count_q[i] == DUR_W'(1)) begin
          state_d[i] = V_IDLE;
        end
      end

      // A load overrides any beat or phase advance on the same cycle.
      if (load_new_note[i]) begin
        note_d[i]  = note_to_load[i*NOTE_W +: NOTE_W];
        count_d[i] = duration_to_load[i*DUR_W +: DUR_W];
        phase_d[i] = '0;
        state_d[i] = (duration_to_load[i*DUR_W +: DUR_W] == '0) ? V_IDLE : V_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= V_IDLE;
        note_q[i]  <= '0;
        count_q[i] <= '0;
        phase_q[i] <= '0;
        wave_q[i]  <= '0;
      end
      stage1_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        state_q[i] <= state_d[i];
        note_q[i]  <= note_d[i];
        count_q[i] <= count_d[i];
        phase_q[i] <= phase_d[i];
        wave_q[i]  <= wave_d[i];
      end
      stage1_valid <= generate_next_sample;
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + SUM_W'(wave_q[i]);
    end
    mix_shifted = mix_sum >>> SHIFT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= stage1_valid;
      if (stage1_valid) begin
        sample_out <= mix_shifted[SAMPLE_W-1:0];
      end
    end
  end

endmodule

// File: doc/poly_note_player.md
Name: poly_note_player

Overview:
Parametrised multi-voice successor to the single-voice note player. It holds NUM_VOICES independent notes, each with its own beat-counted duration and phase accumulator. Each voice produces a selectable waveform: square, sawtooth or triangle. On every codec sample request the block mixes all active voices into one signed sample, so a song reader can drive chords or overlapping notes into the codec path.

Parameters:
NUM_VOICES, 4, number of voices; power of two, 1..8.
NOTE_W, 6, note code width; code 0 is a rest.
DUR_W, 6, duration width, in beats.
PHASE_W, 20, phase accumulator and step width.
SAMPLE_W, 16, output sample width (signed).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
play_enable  in  1  1 = play; 0 = pause (durations and phases frozen)
wave_mode  in  2  00 square, 01 sawtooth, 10 triangle, 11 silence
load_new_note  in  NUM_VOICES  per-voice one-cycle load strobe
note_to_load  in  NUM_VOICES*NOTE_W  packed per-voice note codes; voice i at [i*NOTE_W +: NOTE_W]
duration_to_load  in  NUM_VOICES*DUR_W  packed per-voice durations
done_with_note  out  NUM_VOICES  per-voice level; 1 = voice idle
beat  in  1  one-cycle 48 Hz beat pulse
generate_next_sample  in  1  one-cycle codec sample request
sample_out  out  SAMPLE_W  signed mixed sample
new_sample_ready  out  1  one-cycle pulse; sample_out valid

Behaviour:
- Reset (reset = 0, asynchronous):
  - all voices inactive
  - done_with_note = all 1s
  - phases = 0, remaining counts = 0
  - sample_out = 0, new_sample_ready = 0
- Per-voice states: IDLE / ACTIVE.
- Load: load_new_note[i] = 1 in any state, independent of play_enable.
  - Next cycle: voice i captures its note and duration, phase = 0, done_with_note[i] = 0, state = ACTIVE.
  - A load with duration 0 instead gives done_with_note[i] = 1 and IDLE on the next cycle.
- Beat: when beat = 1 and play_enable = 1, every ACTIVE voice decrements its remaining count.
  - A voice whose count goes 1 -> 0 enters IDLE, and done_with_note[i] = 1 on the next cycle.
  - done_with_note[i] then holds until the next load of voice i.
- Load and beat in the same cycle on voice i: load wins; that beat is not applied to the new note.
- Step lookup: note_step_rom maps note code to step.
  - code 0 -> 0
  - code n -> round(f(n) * 2^PHASE_W / 48000), with f(n) = 440 * 2^((n-49)/12)
- Pipeline, with generate_next_sample = 1 at cycle t:
  - Stage 1 (t+1): each ACTIVE voice with play_enable = 1 adds its step to its phase (mod 2^PHASE_W). It then forms its waveform value v_i from the post-add phase p:
    - square: +(2^(SAMPLE_W-1) - 1) if the phase MSB is 0, else -(2^(SAMPLE_W-1) - 1)
    - sawtooth: top SAMPLE_W phase bits with the MSB inverted
    - triangle: top SAMPLE_W+1 bits folded about the midpoint, scaled to full signed range
    - silence: 0
    - IDLE voices, rests, or play_enable = 0: v_i = 0
  - Stage 2 (t+2): mix = sign-extended sum of all v_i, arithmetically shifted right by log2(NUM_VOICES). This is registered to sample_out, with new_sample_ready = 1 for exactly one cycle.
- Fixed latency of 2 cycles. Back-to-back requests on consecutive cycles are legal; each one produces its own ready pulse.
- play_enable = 0 still answers every request, with a zero sample, so the codec is never starved.
- wave_mode is sampled in stage 1; a mid-note change affects only later samples.

Decomposition:
- Package poly_note_pkg:
  - wave_mode encodings WAVE_SQUARE / WAVE_SAW / WAVE_TRI / WAVE_OFF
  - sample rate constant 48000
  - NOTE_REST = 0
- Sub-module note_step_rom: combinational, NOTE_W in, PHASE_W out, 64-entry table.
  - Instanced once per voice, or time-shared if area requires.

Test Plan:
1. Reset hold, release -> done_with_note = 4'b1111, sample_out = 0; 3 sample requests give 3 ready pulses, each at t+2, all sample 0.
2. Load voice 0, note 49, duration 3, square, play_enable = 1 -> step 9612. First request: phase 9612, v0 = +32767, sample_out = 32767 >>> 2 = 8191. After 3 beats, done_with_note[0] = 1 and later samples are 0.
3. Voices 0 and 1 loaded with note 49, square, 1st request -> sample_out = (32767 + 32767) >>> 2 = 16383. With voice 1 on note 0 (rest) -> 8191.
4. play_enable = 0 for 5 beats mid-note (duration 3, 1 beat elapsed) -> remaining count stays 2, phase frozen, ready pulses carry 0. After re-enable, done asserts exactly 2 beats later.
5. Load and beat in the same cycle on voice 2 (duration 4) -> done asserts after 4 further beats. Load with duration 0 -> done_with_note[2] = 1 the next cycle.
6. Async reset asserted between a request and its ready pulse -> no ready pulse, all outputs return to their reset values immediately.
